// File: rtl/forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_scoreboard
// Description : Shadow of in-flight register writes; per-operand forward
//               selects and load-use stall for the instruction in decode.
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_scoreboard #(
    parameter int REG_AW    = 5,
    parameter int NSRC      = 2,
    parameter int FWD_DEPTH = 2,
    parameter int CNT_W     = 16,
    localparam int SELW     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   issue_valid,
    input  logic                   issue_wen,
    input  logic [REG_AW-1:0]      issue_wsel,
    input  logic [SELW-1:0]        issue_rdy_stg,
    input  logic [NSRC*REG_AW-1:0] src_rsel,
    input  logic [NSRC-1:0]        src_used,
    input  logic                   hold,
    input  logic [FWD_DEPTH:0]     flush_mask,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam logic [SELW-1:0] c_max_stg = SELW'(FWD_DEPTH);
    localparam logic [SELW-1:0] c_min_stg = SELW'(1);

    logic [FWD_DEPTH:1] r_v;
    logic [REG_AW-1:0]  r_wsel [1:FWD_DEPTH];
    logic [SELW-1:0]    r_rdy  [1:FWD_DEPTH];
    logic [CNT_W-1:0]   r_stall_cnt;

    logic [NSRC-1:0]    w_op_stall;
    logic [SELW-1:0]    w_rdy_norm;
    logic               w_accept;

    always_comb begin
        w_rdy_norm = issue_rdy_stg;
        if (issue_rdy_stg == '0)
            w_rdy_norm = c_min_stg;
        else if (issue_rdy_stg > c_max_stg)
            w_rdy_norm = c_max_stg;
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_op
        logic [REG_AW-1:0] w_src;
        logic              w_live;
        logic              w_hit;
        logic              w_late;
        logic [SELW-1:0]   w_stg;

        assign w_src  = src_rsel[i*REG_AW +: REG_AW];
        assign w_live = src_used[i] && (w_src != '0);

        // Scan oldest to youngest so the youngest match is the one kept.
        always_comb begin
            w_hit  = 1'b0;
            w_late = 1'b0;
            w_stg  = '0;
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (r_v[k] && (r_wsel[k] == w_src)) begin
                    w_hit  = 1'b1;
                    w_stg  = SELW'(k);
                    w_late = (r_rdy[k] > SELW'(k));
                end
            end
        end

        assign w_op_stall[i]             = w_live & w_hit & w_late;
        assign fwd_sel[i*SELW +: SELW]   = (w_live & w_hit & ~w_late) ? w_stg : '0;
    end

    assign stall     = issue_valid & (|w_op_stall);
    assign w_accept  = issue_valid & ~stall & ~hold & ~flush_mask[0];
    assign stall_cnt = r_stall_cnt;

    // Flush clears validity in place even while the pipeline is held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_v <= '0;
        end else if (!hold) begin
            r_v[1] <= w_accept & issue_wen & (issue_wsel != '0);
            for (int k = 1; k < FWD_DEPTH; k++)
                r_v[k+1] <= r_v[k] & ~flush_mask[k];
        end else begin
            for (int k = 1; k <= FWD_DEPTH; k++)
                r_v[k] <= r_v[k] & ~flush_mask[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (!hold) begin
            r_wsel[1] <= issue_wsel;
            r_rdy[1]  <= w_rdy_norm;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_wsel[k+1] <= r_wsel[k];
                r_rdy[k+1]  <= r_rdy[k];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_stall_cnt <= '0;
        else if (stall && !hold && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_forwarding_scoreboard
// Description : Directed vector bench for forwarding_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forwarding_scoreboard;

    localparam int REG_AW    = 5;
    localparam int NSRC      = 2;
    localparam int FWD_DEPTH = 2;
    localparam int CNT_W     = 3;
    localparam int SELW      = 2;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic                   issue_valid;
    logic                   issue_wen;
    logic [REG_AW-1:0]      issue_wsel;
    logic [SELW-1:0]        issue_rdy_stg;
    logic [NSRC*REG_AW-1:0] src_rsel;
    logic [NSRC-1:0]        src_used;
    logic                   hold;
    logic [FWD_DEPTH:0]     flush_mask;
    logic [NSRC*SELW-1:0]   fwd_sel;
    logic                   stall;
    logic [CNT_W-1:0]       stall_cnt;

    forwarding_scoreboard #(
        .REG_AW    (REG_AW),
        .NSRC      (NSRC),
        .FWD_DEPTH (FWD_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .issue_valid   (issue_valid),
        .issue_wen     (issue_wen),
        .issue_wsel    (issue_wsel),
        .issue_rdy_stg (issue_rdy_stg),
        .src_rsel      (src_rsel),
        .src_used      (src_used),
        .hold          (hold),
        .flush_mask    (flush_mask),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .stall_cnt     (stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       v;
        logic       wen;
        logic [4:0] wd;
        logic [1:0] rdy;
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] used;
        logic       hold;
        logic [2:0] flush;
        logic [1:0] f0;
        logic [1:0] f1;
        logic       st;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [20];
    int   nvec = 0;
    int   nmis = 0;

    task automatic drive(input logic v, input logic wen, input logic [4:0] wd,
                         input logic [1:0] rdy, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic hd, input logic [2:0] fl);
        issue_valid   = v;
        issue_wen     = wen;
        issue_wsel    = wd;
        issue_rdy_stg = rdy;
        src_rsel      = {s1, s0};
        src_used      = used;
        hold          = hd;
        flush_mask    = fl;
    endtask

    task automatic check(input string name, input logic [1:0] f0, input logic [1:0] f1,
                         input logic st, input logic [2:0] cnt);
        nvec++;
        if (fwd_sel !== {f1, f0} || stall !== st || stall_cnt !== cnt) begin
            nmis++;
            $display("FAIL %s: got fwd_sel=%h stall=%b stall_cnt=%0d, expected fwd_sel=%h stall=%b stall_cnt=%0d",
                     name, fwd_sel, stall, stall_cnt, {f1, f0}, st, cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //           v  wen wd  rdy s0  s1 used hd flush  f0 f1 st cnt
        tbl[0]  = '{0, 0,  0,  0,  0,  0, 0,  0, 3'b000, 0, 0, 0, 0};
        tbl[1]  = '{1, 1,  3,  1,  0,  0, 0,  0, 3'b000, 0, 0, 0, 0};
        tbl[2]  = '{1, 1,  5,  1,  3,  4, 3,  0, 3'b000, 1, 0, 0, 0};
        tbl[3]  = '{1, 0,  0,  1,  3,  5, 3,  0, 3'b000, 2, 1, 0, 0};
        tbl[4]  = '{1, 1,  8,  2,  0,  0, 0,  0, 3'b000, 0, 0, 0, 0};
        tbl[5]  = '{1, 1,  9,  1,  8,  0, 1,  0, 3'b000, 0, 0, 1, 0};
        tbl[6]  = '{1, 1,  9,  1,  8,  0, 1,  0, 3'b000, 2, 0, 0, 1};
        tbl[7]  = '{1, 1,  7,  1,  9,  0, 1,  0, 3'b000, 1, 0, 0, 1};
        tbl[8]  = '{1, 1,  7,  1,  9,  0, 1,  0, 3'b000, 2, 0, 0, 1};
        tbl[9]  = '{1, 0,  0,  1,  7,  7, 3,  0, 3'b000, 1, 1, 0, 1};
        tbl[10] = '{1, 1,  6,  1,  7,  0, 1,  0, 3'b000, 2, 0, 0, 1};
        tbl[11] = '{1, 1,  0,  1,  0,  6, 1,  0, 3'b000, 0, 0, 0, 1};
        tbl[12] = '{1, 0,  0,  1,  6,  0, 3,  0, 3'b000, 2, 0, 0, 1};
        tbl[13] = '{1, 1, 10,  3,  0,  0, 0,  0, 3'b000, 0, 0, 0, 1};
        tbl[14] = '{0, 0,  0,  1, 10,  0, 1,  0, 3'b000, 0, 0, 0, 1};
        tbl[15] = '{1, 0,  0,  1, 10,  0, 1,  0, 3'b000, 2, 0, 0, 1};
        tbl[16] = '{1, 1, 11,  0,  0,  0, 0,  0, 3'b000, 0, 0, 0, 1};
        tbl[17] = '{1, 0,  0,  1, 11,  0, 1,  0, 3'b000, 1, 0, 0, 1};
        tbl[18] = '{1, 1, 12,  2,  0,  0, 0,  0, 3'b001, 0, 0, 0, 1};
        tbl[19] = '{1, 0,  0,  1, 12,  0, 1,  0, 3'b000, 0, 0, 0, 1};

        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        #12;
        check("reset", 0, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].v, tbl[i].wen, tbl[i].wd, tbl[i].rdy, tbl[i].s0, tbl[i].s1,
                  tbl[i].used, tbl[i].hold, tbl[i].flush);
            #1;
            check($sformatf("vec%0d", i), tbl[i].f0, tbl[i].f1, tbl[i].st, tbl[i].cnt);
            @(negedge CLK);
        end

        // Load in stage 1 held for three cycles; flush stage 1 on the last.
        drive(1, 1, 8, 2, 0, 0, 0, 0, 3'b000);
        #1 check("hold_lw", 0, 0, 0, 1);
        @(negedge CLK);
        for (int h = 0; h < 3; h++) begin
            drive(1, 1, 9, 1, 8, 0, 1, 1, (h == 2) ? 3'b010 : 3'b000);
            #1 check($sformatf("hold_cyc%0d", h), 0, 0, 1, 1);
            @(negedge CLK);
        end
        drive(1, 1, 9, 1, 8, 0, 1, 0, 3'b000);
        #1 check("after_flush", 0, 0, 0, 1);
        @(negedge CLK);

        // Reset asserted between edges while decode is stalled.
        drive(1, 1, 8, 2, 0, 0, 0, 0, 3'b000);
        #1 check("rst_lw", 0, 0, 0, 1);
        @(negedge CLK);
        drive(1, 1, 9, 1, 8, 0, 1, 0, 3'b000);
        #1 check("rst_prestall", 0, 0, 1, 1);
        #2 RST = 1'b1;
        #1 check("rst_async", 0, 0, 0, 0);
        @(negedge CLK);
        check("rst_held", 0, 0, 0, 0);
        RST = 1'b0;
        #1 check("rst_empty", 0, 0, 0, 0);
        @(negedge CLK);

        // Repeated load-use stalls drive the 3-bit counter into saturation.
        for (int n = 1; n <= 9; n++) begin
            drive(1, 1, 8, 2, 0, 0, 0, 0, 3'b000);
            @(negedge CLK);
            drive(1, 1, 9, 1, 8, 0, 1, 0, 3'b000);
            #1 check($sformatf("sat_stall%0d", n), 0, 0, 1, 3'((n - 1 > 7) ? 7 : n - 1));
            @(negedge CLK);
            #1 check($sformatf("sat_fwd%0d", n), 2, 0, 0, 3'((n > 7) ? 7 : n));
            @(negedge CLK);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit.
- Keeps a registered shadow of in-flight register writes, one entry per pipeline stage past decode, tracked through FWD_DEPTH stages.
- Produces per-operand forward selects and a load-use/multi-cycle stall for the instruction in decode.
- Supports any operand count, any forwarding depth, per-instruction result-ready stage, pipeline hold, per-stage flush and a stall-cycle counter.
- Sits between decode and the EX operand muxes.

Parameters:
- REG_AW, 5, register index width; register 0 is never a hazard.
- NSRC, 2, source operands per instruction.
- FWD_DEPTH, 2, forwarding stages tracked. Stage k drives forward bus k.
- CNT_W, 16, stall counter width.
- Derived, not a parameter: SELW = $clog2(FWD_DEPTH+1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_wen  in  1  decode instruction writes a register.
- issue_wsel  in  REG_AW  decode destination register.
- issue_rdy_stg  in  SELW  first stage (1..FWD_DEPTH) at which the result is on its forward bus.
- src_rsel  in  NSRC*REG_AW  decode source registers; operand i is at bits [i*REG_AW +: REG_AW].
- src_used  in  NSRC  operand i is actually read.
- hold  in  1  freeze the whole pipeline (e.g. memory wait).
- flush_mask  in  FWD_DEPTH+1  bit 0 kills the decode instruction; bit k kills stage k.
- fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = forward bus k.
- stall  out  1  decode must not advance.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State per stage k=1..FWD_DEPTH: {v, wsel, rdy}.
- Reset (async, RST=1): all v=0, stall_cnt=0. As a consequence fwd_sel=0 and stall=0 while reset is held. Reset mid-operation discards all entries immediately.
- Operand i is live when src_used[i]=1 and src_rsel_i != 0.
- Operand i matches stage k when v[k]=1 and wsel[k]=src_rsel_i.
- Live operand with no match: fwd_sel_i = 0, no stall from that operand.
- Live operand with a match: let k be the youngest matching stage (smallest k); only k is considered.
  - If rdy[k] <= k: fwd_sel_i = k.
  - Else: that operand raises stall, and fwd_sel_i = 0.
- stall = OR over operands, gated by issue_valid. fwd_sel and stall are combinational from registered state plus decode inputs; zero-cycle latency.
- accept = issue_valid & ~stall & ~hold & ~flush_mask[0].
- Next state when hold=0:
  - stage1 <= {accept & issue_wen & (issue_wsel != 0), issue_wsel, issue_rdy_stg}. A stalled or rejected issue inserts a bubble (v=0).
  - stage k+1 <= stage k, with v cleared when flush_mask[k]=1.
  - Stage FWD_DEPTH contents retire. The register file is write-before-read, so retired writes are no longer hazards.
- Next state when hold=1:
  - No shift and no accept.
  - flush_mask[k] still clears v[k] in place; the clear takes priority over hold.
- issue_rdy_stg = 0 is treated as 1. Values greater than FWD_DEPTH are treated as FWD_DEPTH.
- Simultaneous flush and match: forwarding and stall use current (pre-flush) state. The flush takes effect at the next edge.
- stall_cnt increments on every edge where stall=1 and hold=0. It saturates at all-ones and does not wrap.

Test Plan (FWD_DEPTH=2, NSRC=2):
- Back-to-back ALU: issue add r3 (rdy=1), then sub r5,r3,r4 → one cycle later fwd_sel0=1, fwd_sel1=0, stall=0.
- Load-use: issue lw r8 (rdy=2), next instruction reads r8 → stall=1 for exactly 1 cycle with fwd_sel0=0. Bubble enters stage 1. Next cycle fwd_sel0=2, stall=0. stall_cnt=1.
- Youngest wins: r7 is written at both stage 2 (rdy=1) and stage 1 (rdy=1); decode reads r7 in both operands → fwd_sel0=fwd_sel1=1.
- r0 and unused operands: writer of r0, then reader of r0 with src_used=2'b01 and src_rsel1 matching stage 1 → all fwd_sel=0, stall=0.
- Hold and flush: lw r8 in stage 1, hold=1 for 3 cycles → stall stays 1 and stall_cnt unchanged. Apply flush_mask=3'b010 during hold → next cycle stall=0, fwd_sel0=0.
- Async reset mid-stall: assert RST between edges → stall=0, fwd_sel=0, stall_cnt=0 immediately. After release, the first issue sees an empty shadow.
